// File: rtl/wb_mux_n_pkg.sv
// Shared definitions for the wb_mux_n interconnect.
//   wb_state_t     : FSM state encoding (IDLE=0, ACTIVE=1, ERR=2)
//   ERR_COUNT_MAX  : saturation value of the sticky error counter
//   cnt_width()    : width of a counter that must reach max_count-1
package wb_mux_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } wb_state_t;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  // The watchdog counts 0 .. max_count-1, so clog2(max_count) bits suffice;
  // keep at least one bit for max_count == 1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/wb_mux_n_if.sv
// Single Wishbone B4 classic link between the host master and the mux.
//   adr, dat_w, we, sel, stb, cyc : master -> mux
//   dat_r, ack, err, rty          : mux -> master
// Handshake: the master holds cyc&stb (and adr/dat_w/we/sel stable) until a
// cycle in which exactly that transfer is terminated by ack, err or rty; the
// transfer completes at the clock edge ending that cycle.
interface wb_mux_n_if #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_mux_n_addr_decode.sv
// Combinational priority address decoder.
//   adr      : master address
//   base     : N_SLAVES packed base addresses, slice i = slave i
//   msk      : N_SLAVES packed address masks
//   sel      : one-hot select of the lowest matching slave
//   hit      : at least one slave matched
module wb_mux_n_addr_decode #(
  parameter int N_SLAVES   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]          adr,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0] base,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0] msk,
  output logic [N_SLAVES-1:0]            sel,
  output logic                           hit
);
  import wb_mux_n_pkg::*;

  always_comb begin
    logic                  found;
    logic [ADDR_WIDTH-1:0] m;
    sel   = '0;
    found = 1'b0;
    m     = '0;
    // Ascending scan; the first match blocks all higher indices.
    for (int i = 0; i < N_SLAVES; i++) begin
      m = msk[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (!found && ((adr & m) == (base[i*ADDR_WIDTH +: ADDR_WIDTH] & m))) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    hit = found;
  end

endmodule

// File: rtl/wb_mux_n.sv
// N-way Wishbone B4 classic interconnect: one host master, N_SLAVES slaves.
// Address decode is registered in IDLE; unmapped accesses get a one-cycle
// bus error; a watchdog terminates slaves that never respond; err_count and
// err_adr hold sticky debug status.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wbm             : host master link (mux is the slave end)
//   wbs_adr_o/dat_o/sel_o : broadcast copies of master adr/dat/sel
//   wbs_dat_i       : per-slave read data
//   wbs_we/stb/cyc_o: per-slave controls, only for the selected slave
//   wbs_ack/err/rty_i : per-slave terminations
//   wbs_addr, wbs_addr_msk : per-slave base address and mask
//   err_count       : saturating count of error terminations
//   err_adr         : address of the last errored access
//   fsm_state       : current FSM state
module wb_mux_n #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 16,
  parameter int N_SLAVES     = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  wb_mux_n_if.slave                        wbm,
  output logic [N_SLAVES*ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [N_SLAVES*DATA_WIDTH-1:0]   wbs_dat_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [N_SLAVES-1:0]              wbs_we_o,
  output logic [N_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
  output logic [N_SLAVES-1:0]              wbs_stb_o,
  output logic [N_SLAVES-1:0]              wbs_cyc_o,
  input  logic [N_SLAVES-1:0]              wbs_ack_i,
  input  logic [N_SLAVES-1:0]              wbs_err_i,
  input  logic [N_SLAVES-1:0]              wbs_rty_i,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0]   wbs_addr,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0]   wbs_addr_msk,
  output logic [7:0]                       err_count,
  output logic [ADDR_WIDTH-1:0]            err_adr,
  output wb_mux_n_pkg::wb_state_t          fsm_state
);
  import wb_mux_n_pkg::*;

  localparam int WD_W = cnt_width(TIMEOUT);

  wb_state_t             state;
  logic [N_SLAVES-1:0]   sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [WD_W-1:0]       wd_cnt;

  logic [N_SLAVES-1:0]   dec_sel;
  logic                  dec_hit;

  logic [DATA_WIDTH-1:0] slv_dat;
  logic                  slv_ack;
  logic                  slv_err;
  logic                  slv_rty;

  logic live;
  logic resp;
  logic wd_expired;
  logic timeout_hit;
  logic gate;
  logic err_event;

  wb_mux_n_addr_decode #(
    .N_SLAVES  (N_SLAVES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .adr (wbm.adr),
    .base(wbs_addr),
    .msk (wbs_addr_msk),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  // Broadcast bus; only stb/cyc/we select the target.
  assign wbs_adr_o = {N_SLAVES{wbm.adr}};
  assign wbs_dat_o = {N_SLAVES{wbm.dat_w}};
  assign wbs_sel_o = {N_SLAVES{wbm.sel}};

  // Response mux driven by the registered one-hot select.
  always_comb begin
    slv_dat = '0;
    slv_ack = 1'b0;
    slv_err = 1'b0;
    slv_rty = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) begin
        slv_dat = slv_dat | wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        slv_ack = slv_ack | wbs_ack_i[i];
        slv_err = slv_err | wbs_err_i[i];
        slv_rty = slv_rty | wbs_rty_i[i];
      end
    end
  end

  // Dropping cyc in ACTIVE abandons the transfer immediately, so every
  // slave-side signal and every response is qualified by the live cyc.
  assign live        = (state == ST_ACTIVE) && wbm.cyc;
  assign resp        = slv_ack || slv_err || slv_rty;
  // Fires on the TIMEOUT-th ACTIVE cycle without a response. The slave
  // cyc/stb gating uses only the count so there is no combinational path
  // from a slave's ack back to its own cyc; a response in this same cycle
  // still wins over the timeout error.
  assign wd_expired  = live && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign timeout_hit = wd_expired && !resp;
  assign gate        = live && !wd_expired;

  assign wbs_cyc_o = gate              ? sel_q : '0;
  assign wbs_stb_o = (gate && wbm.stb) ? sel_q : '0;
  assign wbs_we_o  = (gate && wbm.we)  ? sel_q : '0;

  // Ack and err both pass through; a master that checks err first sees it.
  assign wbm.ack   = live && slv_ack;
  assign wbm.rty   = live && slv_rty;
  assign wbm.err   = (state == ST_ERR) || (live && slv_err) || timeout_hit;
  assign wbm.dat_r = live ? slv_dat : '0;

  assign err_event = wbm.err;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      adr_q     <= '0;
      wd_cnt    <= '0;
      err_count <= '0;
      err_adr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wbm.cyc && wbm.stb) begin
            sel_q  <= dec_sel;
            adr_q  <= wbm.adr;
            wd_cnt <= '0;
            state  <= dec_hit ? ST_ACTIVE : ST_ERR;
          end
        end
        ST_ACTIVE: begin
          if (!wbm.cyc || resp || wd_expired) begin
            state <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (err_event) begin
        if (err_count != ERR_COUNT_MAX) begin
          err_count <= err_count + 8'd1;
        end
        err_adr <= adr_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_mux_n.sv
module tb_wb_mux_n;
  import wb_mux_n_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int EW = 2 + DW;

  localparam logic [1:0] K_ACK = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;
  localparam logic [1:0] K_RTY = 2'd3;

  localparam int M_ACK    = 0;
  localparam int M_ERR    = 1;
  localparam int M_RTY    = 2;
  localparam int M_ACKERR = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_mux_n_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) wbm_bus ();

  logic [N*AW-1:0] wbs_adr_o;
  logic [N*DW-1:0] wbs_dat_o;
  logic [N*DW-1:0] wbs_dat_i;
  logic [N-1:0]    wbs_we_o;
  logic [N*SW-1:0] wbs_sel_o;
  logic [N-1:0]    wbs_stb_o;
  logic [N-1:0]    wbs_cyc_o;
  logic [N-1:0]    wbs_ack_i;
  logic [N-1:0]    wbs_err_i;
  logic [N-1:0]    wbs_rty_i;
  logic [N*AW-1:0] wbs_addr;
  logic [N*AW-1:0] wbs_addr_msk;
  logic [7:0]      err_count;
  logic [AW-1:0]   err_adr;
  wb_state_t       fsm_state;

  logic [AW-1:0] base [N];
  logic [AW-1:0] msk  [N];
  logic [DW-1:0] rdat [N];
  int            lat  [N];
  int            mode [N];

  assign wbs_addr     = {base[3], base[2], base[1], base[0]};
  assign wbs_addr_msk = {msk[3], msk[2], msk[1], msk[0]};
  assign wbs_dat_i    = {rdat[3], rdat[2], rdat[1], rdat[0]};

  wb_mux_n #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
    .N_SLAVES(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .wbm(wbm_bus),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i),
    .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i), .wbs_addr(wbs_addr), .wbs_addr_msk(wbs_addr_msk),
    .err_count(err_count), .err_adr(err_adr), .fsm_state(fsm_state)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [N-1:0]  stb_seen;
  logic [N-1:0]  we_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // slave responders: respond in the lat-th cycle of seen strobe (0 = never)
  initial begin
    int cnt [N];
    wbs_ack_i = '0;
    wbs_err_i = '0;
    wbs_rty_i = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (wbs_ack_i[i] || wbs_err_i[i] || wbs_rty_i[i]) begin
          wbs_ack_i[i] = 1'b0;
          wbs_err_i[i] = 1'b0;
          wbs_rty_i[i] = 1'b0;
          cnt[i] = 0;
        end else if (wbs_stb_o[i]) begin
          cnt[i]++;
          if (lat[i] != 0 && cnt[i] == lat[i]) begin
            wbs_ack_i[i] = (mode[i] == M_ACK) || (mode[i] == M_ACKERR);
            wbs_err_i[i] = (mode[i] == M_ERR) || (mode[i] == M_ACKERR);
            wbs_rty_i[i] = (mode[i] == M_RTY);
          end
        end else begin
          cnt[i] = 0;
        end
      end
    end
  end

  // monitor: pops one expectation per terminated transfer
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    logic [1:0]    kind;
    forever begin
      @(negedge clk);
      stb_seen = stb_seen | wbs_stb_o;
      we_seen  = we_seen | wbs_we_o;
      if (!rst && (wbm_bus.ack || wbm_bus.err || wbm_bus.rty)) begin
        kind = wbm_bus.err ? K_ERR : (wbm_bus.ack ? K_ACK : K_RTY);
        got  = {kind, wbm_bus.dat_r};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          check("resp", 64'(got), 64'(exp));
        end
      end
    end
  end

  // master driver: one classic transfer, bounded wait for termination
  task automatic xfer(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] wdat,
                      input logic [1:0] exp_kind, input logic [DW-1:0] exp_dat,
                      output int n, output logic [N-1:0] cyc_at);
    exp_q.push_back({exp_kind, exp_dat});
    @(posedge clk);
    #1;
    wbm_bus.adr   = adr;
    wbm_bus.we    = we;
    wbm_bus.dat_w = wdat;
    wbm_bus.sel   = '1;
    wbm_bus.cyc   = 1'b1;
    wbm_bus.stb   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wbm_bus.ack || wbm_bus.err || wbm_bus.rty) && n < 200);
    cyc_at = wbs_cyc_o;
    if (!(wbm_bus.ack || wbm_bus.err || wbm_bus.rty)) begin
      n_checks++;
      $display("FAIL xfer_wait: got no response expected one at adr %0h", adr);
    end
    @(posedge clk);
    #1;
    wbm_bus.cyc = 1'b0;
    wbm_bus.stb = 1'b0;
    wbm_bus.we  = 1'b0;
  endtask

  initial begin
    int           n;
    logic [N-1:0] cyc_at;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    wbm_bus.adr = '0; wbm_bus.dat_w = '0; wbm_bus.we = 1'b0;
    wbm_bus.sel = '0; wbm_bus.cyc = 1'b0; wbm_bus.stb = 1'b0;
    base[0] = 32'h0000_0000; base[1] = 32'h0000_4000;
    base[2] = 32'h0000_8000; base[3] = 32'h0000_C000;
    for (int i = 0; i < N; i++) begin
      msk[i] = ~32'h3FFF; lat[i] = 1; mode[i] = M_ACK;
    end
    rdat[0] = 32'h0; rdat[1] = 32'h0000_DEAD;
    rdat[2] = 32'h2222_2222; rdat[3] = 32'h3333_3333;
    stb_seen = '0; we_seen = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    check("rst_stb", 64'(wbs_stb_o), 64'(0));
    check("rst_cyc", 64'(wbs_cyc_o), 64'(0));
    check("rst_resp", 64'({wbm_bus.ack, wbm_bus.err, wbm_bus.rty}), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_err_adr", 64'(err_adr), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // broadcast of adr/dat/sel with no cycle in progress
    a = 32'h0000_1234; d = 32'hCAFE_F00D;
    wbm_bus.adr = a; wbm_bus.dat_w = d; wbm_bus.sel = 4'b0101;
    #1;
    check("bcast_adr", 64'(wbs_adr_o), 64'({a, a, a, a}));
    check("bcast_dat", 64'(wbs_dat_o), 64'({d, d, d, d}));
    check("bcast_sel", 64'(wbs_sel_o), 64'(16'h5555));
    check("idle_cyc", 64'(wbs_cyc_o), 64'(0));

    // read slave1, ack in 3rd strobe cycle
    lat[1] = 3; stb_seen = '0;
    xfer(32'h4010, 1'b0, 32'h0, K_ACK, 32'h0000_DEAD, n, cyc_at);
    check("t1_stb_onehot", 64'(stb_seen), 64'(4'b0010));
    check("t1_cycles", 64'(n), 64'(4));

    // write slave2, minimum-latency access
    lat[2] = 1; we_seen = '0;
    xfer(32'h8020, 1'b1, 32'h1234_5678, K_ACK, 32'h2222_2222, n, cyc_at);
    check("t1b_we", 64'(we_seen), 64'(4'b0100));
    check("t1b_cycles", 64'(n), 64'(2));

    // slave3 moved out of the way: 0xC000 becomes unmapped
    base[3] = 32'h0001_0000; msk[3] = ~32'h0000_FFFF; stb_seen = '0;
    xfer(32'hC000, 1'b0, 32'h0, K_ERR, 32'h0, n, cyc_at);
    check("t2_cycles", 64'(n), 64'(2));
    check("t2_no_stb", 64'(stb_seen), 64'(0));
    check("t2_err_count", 64'(err_count), 64'(1));
    check("t2_err_adr", 64'(err_adr), 64'(32'hC000));

    // slave0 never answers: watchdog on the 16th ACTIVE cycle
    lat[0] = 0;
    xfer(32'h0100, 1'b0, 32'h0, K_ERR, 32'h0, n, cyc_at);
    check("t3_cycles", 64'(n), 64'(TO + 1));
    check("t3_cyc_low", 64'(cyc_at), 64'(0));
    check("t3_err_count", 64'(err_count), 64'(2));
    check("t3_err_adr", 64'(err_adr), 64'(32'h0100));

    // overlap: slave2 aliased onto 0x4000, lowest index wins
    base[2] = 32'h4000; lat[1] = 1; stb_seen = '0;
    xfer(32'h4000, 1'b0, 32'h0, K_ACK, 32'h0000_DEAD, n, cyc_at);
    check("t4_route", 64'(stb_seen), 64'(4'b0010));
    base[2] = 32'h8000;

    // master abandons the cycle in its 2nd ACTIVE cycle
    lat[2] = 0;
    @(posedge clk);
    #1;
    wbm_bus.adr = 32'h8010; wbm_bus.we = 1'b0;
    wbm_bus.cyc = 1'b1; wbm_bus.stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_cyc_active", 64'(wbs_cyc_o), 64'(4'b0100));
    @(posedge clk);
    #1;
    wbm_bus.cyc = 1'b0; wbm_bus.stb = 1'b0;
    @(negedge clk);
    check("t5_cyc_drop", 64'(wbs_cyc_o), 64'(0));
    check("t5_stb_drop", 64'(wbs_stb_o), 64'(0));
    @(negedge clk);
    check("t5_idle", 64'(fsm_state), 64'(ST_IDLE));
    check("t5_err_count", 64'(err_count), 64'(2));
    lat[2] = 1;

    // slave error is passed through and counted
    lat[1] = 2; mode[1] = M_ERR;
    xfer(32'h4ABC, 1'b0, 32'h0, K_ERR, 32'h0000_DEAD, n, cyc_at);
    check("t6_err_count", 64'(err_count), 64'(3));
    check("t6_err_adr", 64'(err_adr), 64'(32'h4ABC));
    mode[1] = M_ACK;

    // retry is passed through and not counted
    lat[0] = 1; mode[0] = M_RTY;
    xfer(32'h0200, 1'b0, 32'h0, K_RTY, 32'h0, n, cyc_at);
    check("t7_err_count", 64'(err_count), 64'(3));
    mode[0] = M_ACK;

    // simultaneous ack+err: master sees err
    mode[2] = M_ACKERR;
    xfer(32'h8000, 1'b0, 32'h0, K_ERR, 32'h2222_2222, n, cyc_at);
    check("t8_err_count", 64'(err_count), 64'(4));
    check("t8_err_adr", 64'(err_adr), 64'(32'h8000));
    mode[2] = M_ACK;

    // 300 unmapped accesses saturate the counter
    for (int i = 0; i < 300; i++) begin
      xfer(32'hC000 + 32'(i * 4), 1'b0, 32'h0, K_ERR, 32'h0, n, cyc_at);
    end
    check("t9_sat", 64'(err_count), 64'(255));
    check("t9_err_adr", 64'(err_adr), 64'(32'hC4AC));

    // reset clears sticky status
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t10_err_count", 64'(err_count), 64'(0));
    check("t10_err_adr", 64'(err_adr), 64'(0));
    check("t10_state", 64'(fsm_state), 64'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(posedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
